alu_cmd_ctrl: RTL and testbench

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

---
 rtl/alu_cmd_pkg.sv | 36 +++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_cmd_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_pkg.sv
// Shared types and constants for the ALU command controller: FSM states,
// unit encoding, op-code constants and the queued command payload.
package alu_cmd_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESULT,
        CLEAR
    } state_t;

    localparam logic UNIT_A = 1'b0;
    localparam logic UNIT_B = 1'b1;

    localparam logic [OP_W-1:0] OP_0 = 2'b00;
    localparam logic [OP_W-1:0] OP_1 = 2'b01;
    localparam logic [OP_W-1:0] OP_2 = 2'b10;
    localparam logic [OP_W-1:0] OP_3 = 2'b11;

    typedef struct packed {
        logic              unit;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    // Op code seen by one unit: the command's op if it targets that unit, else zero.
    function automatic logic [OP_W-1:0] op_for(cmd_t c, logic unit);
        return (c.unit == unit) ? c.op : OP_0;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// In-order command queue; DEPTH must be a power of two so pointers wrap naturally.
module alu_cmd_fifo
    import alu_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  cmd_t                   wdata,
    output cmd_t                   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Sequences queued commands onto a two-unit ALU and returns captured results.
// Define ALU_CMD_CTRL_FIFO_EN for a FIFO_DEPTH command queue; otherwise one holding register.
module alu_cmd_ctrl
    import alu_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IRQ_CNT_W  = 8
) (
    input  logic                 alu_clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_unit,
    input  logic [OP_W-1:0]      cmd_op,
    input  logic [DATA_W-1:0]    cmd_a,
    input  logic [DATA_W-1:0]    cmd_b,
    output logic                 alu_enable,
    output logic                 alu_enable_a,
    output logic                 alu_enable_b,
    output logic [OP_W-1:0]      alu_op_a,
    output logic [OP_W-1:0]      alu_op_b,
    output logic [DATA_W-1:0]    alu_in_a,
    output logic [DATA_W-1:0]    alu_in_b,
    output logic                 alu_irq_clr,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic                 alu_irq,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DATA_W-1:0]    res_data,
    output logic                 res_irq,
    output logic [IRQ_CNT_W-1:0] irq_count
);

    state_t state;
    state_t state_next;
    cmd_t   cmd_in;
    cmd_t   head;
    logic   head_valid;
    logic   push;
    logic   pop;
    logic   ready_next;

    assign cmd_in = '{unit: cmd_unit, op: cmd_op, a: cmd_a, b: cmd_b};
    assign push   = cmd_valid && cmd_ready;
    assign pop    = (state == IDLE) && head_valid;

`ifdef ALU_CMD_CTRL_FIFO_EN
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [LVL_W-1:0] level;
    logic             full;
    logic             empty;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (alu_clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (cmd_in),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign head_valid = !empty;
    // Ready for next cycle: full stays full unless popped; otherwise fills only on a lone push at D-1.
    assign ready_next = full ? pop
                             : !(push && !pop && (level == LVL_W'(FIFO_DEPTH - 1)));
`else
    cmd_t hold;
    logic hold_valid;
    logic hold_valid_next;

    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (push) hold <= cmd_in;
            hold_valid <= hold_valid_next;
        end
    end

    assign hold_valid_next = push ? 1'b1 : (pop ? 1'b0 : hold_valid);
    assign head            = hold;
    assign head_valid      = hold_valid;
    assign ready_next      = (state_next == IDLE) && !hold_valid_next;
`endif

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (head_valid) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = RESULT;
            RESULT:  if (res_ready) state_next = res_irq ? CLEAR : IDLE;
            CLEAR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and all registered outputs, decoded from the upcoming state.
    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd_ready    <= 1'b0;
            alu_enable   <= 1'b0;
            alu_enable_a <= 1'b0;
            alu_enable_b <= 1'b0;
            alu_op_a     <= '0;
            alu_op_b     <= '0;
            alu_in_a     <= '0;
            alu_in_b     <= '0;
            alu_irq_clr  <= 1'b1;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_irq      <= 1'b0;
            irq_count    <= '0;
        end else begin
            state        <= state_next;
            cmd_ready    <= ready_next;
            alu_enable   <= (state_next == ISSUE);
            alu_enable_a <= (state_next == ISSUE) && (head.unit == UNIT_A);
            alu_enable_b <= (state_next == ISSUE) && (head.unit == UNIT_B);
            alu_irq_clr  <= (state_next == IDLE) || (state_next == CLEAR);
            res_valid    <= (state_next == RESULT);
            if (pop) begin
                alu_op_a <= op_for(head, UNIT_A);
                alu_op_b <= op_for(head, UNIT_B);
                alu_in_a <= head.a;
                alu_in_b <= head.b;
            end
            if (state == CAPTURE) begin
                res_data <= alu_out;
                res_irq  <= alu_irq;
            end
            if ((state == RESULT) && res_ready && res_irq && (irq_count != '1)) begin
                irq_count <= irq_count + IRQ_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a small registered two-unit ALU model
// (op 00 AND, 01 XOR, 10 OR, 11 ADD; irq = result bit 7).
module tb_alu_cmd_ctrl;

    logic       alu_clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_unit;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       alu_enable;
    logic       alu_enable_a;
    logic       alu_enable_b;
    logic [1:0] alu_op_a;
    logic [1:0] alu_op_b;
    logic [7:0] alu_in_a;
    logic [7:0] alu_in_b;
    logic       alu_irq_clr;
    logic [7:0] alu_out;
    logic       alu_irq;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_irq;
    logic [7:0] irq_count;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef ALU_CMD_CTRL_FIFO_EN
    localparam int N_ACC = 5;
`else
    localparam int N_ACC = 1;
`endif

    alu_cmd_ctrl #(
        .FIFO_DEPTH (4),
        .IRQ_CNT_W  (8)
    ) dut (
        .alu_clk      (alu_clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_unit     (cmd_unit),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_enable   (alu_enable),
        .alu_enable_a (alu_enable_a),
        .alu_enable_b (alu_enable_b),
        .alu_op_a     (alu_op_a),
        .alu_op_b     (alu_op_b),
        .alu_in_a     (alu_in_a),
        .alu_in_b     (alu_in_b),
        .alu_irq_clr  (alu_irq_clr),
        .alu_out      (alu_out),
        .alu_irq      (alu_irq),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_irq      (res_irq),
        .irq_count    (irq_count)
    );

    always #5 alu_clk = ~alu_clk;

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a ^ b;
            2'b10:   return a | b;
            default: return a + b;
        endcase
    endfunction

    // ALU model: latches a result on the enable edge; irq cleared by alu_irq_clr.
    always @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= 8'h00;
            alu_irq <= 1'b0;
        end else if (alu_enable) begin
            alu_out <= alu_f(alu_enable_b ? alu_op_b : alu_op_a, alu_in_a, alu_in_b);
            alu_irq <= alu_f(alu_enable_b ? alu_op_b : alu_op_a, alu_in_a, alu_in_b) >= 8'h80;
        end else if (alu_irq_clr) begin
            alu_irq <= 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge alu_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic u, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_unit = u;
        cmd_op   = op;
        cmd_a    = a;
        cmd_b    = b;
    endtask

    // Push one command, waiting (bounded) for cmd_ready; returns just after the accepting edge.
    task automatic push_cmd(input logic u, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        set_cmd(u, op, a, b);
        cmd_valid = 1'b1;
        for (int n = 0; n < 30 && cmd_ready !== 1'b1; n++) tick();
        check("push_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    logic [7:0] exp_data [5];
    logic       exp_irq  [5];
    int         seen;
    int         nres;
    bit         hs;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        set_cmd(1'b0, 2'b00, 8'h00, 8'h00);
        exp_data = '{8'h33, 8'h90, 8'h41, 8'h90, 8'h05};
        exp_irq  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset values
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_irq_clr", alu_irq_clr, 1);
        check("rst_enable", {alu_enable, alu_enable_a, alu_enable_b}, 0);
        check("rst_drive", {alu_op_a, alu_op_b, alu_in_a, alu_in_b}, 0);
        check("rst_res", {res_valid, res_irq, res_data}, 0);
        check("rst_irq_count", irq_count, 0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", cmd_ready, 0);
        tick();
        check("ready_after_edge", cmd_ready, 1);

        // Unit A OR with irq, CLEAR pulse
        res_ready = 1'b1;
        push_cmd(1'b0, 2'b10, 8'hF0, 8'h08);
        check("t1_idle_clr", alu_irq_clr, 1);
        tick();
        check("t1_issue_en", {alu_enable, alu_enable_a, alu_enable_b}, 3'b110);
        check("t1_issue_op", {alu_op_a, alu_op_b}, 4'b1000);
        check("t1_issue_in", {alu_in_a, alu_in_b}, 16'hF008);
        check("t1_issue_clr", alu_irq_clr, 0);
        tick();
        check("t1_capture_en", {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr, res_valid}, 0);
        tick();
        check("t1_result", {res_valid, res_irq, res_data}, {2'b11, 8'hF8});
        check("t1_result_clr", alu_irq_clr, 0);
        tick();
        check("t1_clear", {res_valid, alu_irq_clr}, 2'b01);
        check("t1_irq_count", irq_count, 1);
        check("t1_hold_in", {alu_in_a, alu_op_a}, {8'hF0, 2'b10});
        tick();
        check("t1_idle_after", {alu_irq_clr, alu_enable}, 2'b10);

        // Unit B ADD with irq
        push_cmd(1'b1, 2'b11, 8'h0F, 8'hF0);
        tick();
        check("t2_issue_en", {alu_enable, alu_enable_a, alu_enable_b}, 3'b101);
        check("t2_issue_op", {alu_op_a, alu_op_b}, 4'b0011);
        tick();
        tick();
        check("t2_result", {res_valid, res_irq, res_data}, {2'b11, 8'hFF});
        tick();
        tick();
        check("t2_irq_count", irq_count, 2);

        // Unit A AND, no irq, result held while res_ready low
        res_ready = 1'b0;
        push_cmd(1'b0, 2'b00, 8'h12, 8'h34);
        tick();
        tick();
        tick();
        check("t3_result", {res_valid, res_irq, res_data}, {2'b10, 8'h10});
        tick();
        check("t3_result_hold", {res_valid, res_irq, res_data}, {2'b10, 8'h10});
        res_ready = 1'b1;
        tick();
        check("t3_exit", {res_valid, alu_irq_clr}, 2'b01);
        check("t3_irq_count", irq_count, 2);
        repeat (2) tick();

        // Back-to-back pushes while results stall
        res_ready = 1'b0;
        begin
            logic [1:0] ops [6]  = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01};
            logic [7:0] as_ [6]  = '{8'h3C, 8'h70, 8'h01, 8'hF3, 8'h80, 8'hAA};
            logic [7:0] bs_ [6]  = '{8'h0F, 8'h20, 8'h40, 8'h9C, 8'h85, 8'h55};
            for (int i = 0; i < 6; i++) begin
                set_cmd(1'(i % 2), ops[i], as_[i], bs_[i]);
                cmd_valid = 1'b1;
                check($sformatf("t4_ready_%0d", i), cmd_ready, (i < N_ACC) ? 1 : 0);
                tick();
            end
        end
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("t4_stall_valid", {res_valid, res_data}, {1'b1, 8'h33});
        check("t4_stall_ready", cmd_ready, 0);
        res_ready = 1'b1;
        for (int k = 0; k < N_ACC; k++) begin
            for (int n = 0; n < 20 && res_valid !== 1'b1; n++) tick();
            check($sformatf("t4_res_%0d", k), {res_valid, res_irq, res_data}, {1'b1, exp_irq[k], exp_data[k]});
            tick();
        end
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            if (res_valid === 1'b1) seen++;
            tick();
        end
        check("t4_no_extra", seen, 0);
        check("t4_irq_count", irq_count, (N_ACC == 5) ? 4 : 2);

        // Reset asserted during CAPTURE
        set_cmd(1'b0, 2'b10, 8'h80, 8'h01);
        cmd_valid = 1'b1;
        check("t5_ready", cmd_ready, 1);
        tick();
`ifdef ALU_CMD_CTRL_FIFO_EN
        set_cmd(1'b1, 2'b11, 8'h81, 8'h01);
`else
        cmd_valid = 1'b0;
`endif
        tick();
        cmd_valid = 1'b0;
        check("t5_issue", alu_enable, 1);
        tick();
        check("t5_capture", {alu_enable, res_valid}, 0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_res", {res_valid, res_irq, res_data}, 0);
        check("t5_rst_clr", {alu_irq_clr, cmd_ready}, 2'b10);
        check("t5_rst_count", irq_count, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("t5_ready_after", cmd_ready, 1);
        seen = 0;
        for (int n = 0; n < 15; n++) begin
            if (res_valid === 1'b1 || alu_enable === 1'b1) seen++;
            tick();
        end
        check("t5_nothing_runs", seen, 0);

        // Saturating irq counter
        set_cmd(1'b0, 2'b10, 8'h80, 8'h00);
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        nres = 0;
        for (int c = 0; c < 4000 && nres < 256; c++) begin
            hs = (res_valid === 1'b1);
            tick();
            if (hs) begin
                nres++;
                if (nres == 1)   check("t6_cnt_1", irq_count, 8'h01);
                if (nres == 254) check("t6_cnt_254", irq_count, 8'hFE);
                if (nres == 255) check("t6_cnt_255", irq_count, 8'hFF);
                if (nres == 256) check("t6_cnt_256", irq_count, 8'hFF);
            end
        end
        check("t6_results", nres, 256);
        cmd_valid = 1'b0;
        repeat (40) tick();
        check("t6_drained", {res_valid, irq_count}, {1'b0, 8'hFF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
